// File: rtl/plcp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plcp_pkg
// Description : Shared types and constants for the PLCP framer: FSM state
//               encoding, SIGNAL RATE codes, N_DBPS lookup, field lengths and
//               the preamble bit pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package plcp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_PREAMBLE   = 4'd1,
    ST_SIG_RATE   = 4'd2,
    ST_SIG_RSVD   = 4'd3,
    ST_SIG_LEN    = 4'd4,
    ST_SIG_PARITY = 4'd5,
    ST_SIG_TAIL   = 4'd6,
    ST_SERVICE    = 4'd7,
    ST_PSDU       = 4'd8,
    ST_DTAIL      = 4'd9,
    ST_PAD        = 4'd10
  } plcp_state_t;

  // SIGNAL RATE codes, written R1..R4 from MSB to LSB
  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  localparam int RATE_BITS    = 4;
  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;

  // Preamble alternates 1,0,...; indexed by the LSB of the bit counter
  localparam logic [1:0] PREAMBLE_PATTERN = 2'b01;

  // Data bits per OFDM symbol; 0 flags an unsupported RATE code
  function automatic logic [7:0] ndbps_of(input logic [3:0] rate);
    case (rate)
      RATE_6M:  ndbps_of = 8'd24;
      RATE_9M:  ndbps_of = 8'd36;
      RATE_12M: ndbps_of = 8'd48;
      RATE_18M: ndbps_of = 8'd72;
      RATE_24M: ndbps_of = 8'd96;
      RATE_36M: ndbps_of = 8'd144;
      RATE_48M: ndbps_of = 8'd192;
      RATE_54M: ndbps_of = 8'd216;
      default:  ndbps_of = 8'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/plcp_lfsr7.sv
`default_nettype none
// ============================================================================
// Module      : plcp_lfsr7
// Description : x^7+x^4+1 additive scrambler sequence generator. 'out' is the
//               current key bit; 'load' reseeds, 'step' advances one bit.
// Revision    : 1.0 - initial release
// ============================================================================
module plcp_lfsr7 #(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic step,
  output logic out
);

  // state[0] is the most recent feedback bit, state[6] the oldest
  logic [6:0] state;

  assign out = state[6] ^ state[3];

  // Reseed on load, otherwise shift the feedback bit in on each step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= {state[5:0], out};
    end
  end

endmodule
`default_nettype wire

// File: rtl/plcp_framer.sv
`default_nettype none
// ============================================================================
// Module      : plcp_framer
// Description : Serial PLCP frame builder: preamble, SIGNAL field, SERVICE,
//               PSDU pass-through, data tail and pad to a whole number of
//               OFDM symbols, with valid/ready handshakes on both sides.
//               Optional build macro PLCP_FRAMER_SCRAMBLER_EN enables the
//               internal data-field scrambler.
// Revision    : 1.0 - initial release
// ============================================================================
module plcp_framer
  import plcp_pkg::*;
#(
  parameter int         PREAMBLE_BITS = 96,
  parameter int         LEN_W         = 12,
  parameter logic [6:0] SCR_SEED      = 7'h7F
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Rate,
  input  logic [LEN_W-1:0] Length,
  input  logic             In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic             Out_Bit,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Out_Coded,
  output logic             Out_Scrambled,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  // One shared bit counter, wide enough for the PSDU (8*Length, no wrap),
  // the preamble and the 16-bit SERVICE field
  localparam int PSDU_W = LEN_W + 3;
  localparam int PRE_W  = (PREAMBLE_BITS > 2) ? $clog2(PREAMBLE_BITS) : 1;
  localparam int CNT_A  = (PSDU_W > PRE_W) ? PSDU_W : PRE_W;
  localparam int CNT_W  = (CNT_A > 5) ? CNT_A : 5;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RATE_BITS - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);
  localparam logic [CNT_W-1:0] SVC_LAST  = CNT_W'(SERVICE_BITS - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_BITS - 1);

  plcp_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       sym_cnt;
  logic [3:0]       rate_q;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       ndbps_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             xfer;
  logic             scr_tag;
  logic             src_bit;
  logic [7:0]       start_ndbps;
  logic [7:0]       sym_next;
  logic [CNT_W-1:0] psdu_last;
  logic [LEN_W-1:0] len_shift;
  logic [3:0]       rate_shift;

  assign start_ndbps = ndbps_of(Rate);
  assign psdu_last   = CNT_W'({len_q, 3'b000}) - CNT_W'(1);
  assign sym_next    = (sym_cnt == ndbps_q - 8'd1) ? 8'd0 : sym_cnt + 8'd1;
  assign len_shift   = len_q >> cnt;
  assign rate_shift  = rate_q << cnt[1:0];

  // Handshake and segment tags decoded from the current state
  always_comb begin
    Out_Valid     = 1'b0;
    In_Ready      = 1'b0;
    Out_Coded     = 1'b0;
    scr_tag       = 1'b0;
    src_bit       = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_PREAMBLE: begin
        Out_Valid = 1'b1;
        src_bit   = PREAMBLE_PATTERN[cnt[0]];
      end
      ST_SIG_RATE: begin
        Out_Valid = 1'b1;
        Out_Coded = 1'b1;
        src_bit   = rate_shift[3];
      end
      ST_SIG_LEN: begin
        Out_Valid = 1'b1;
        Out_Coded = 1'b1;
        src_bit   = len_shift[0];
      end
      ST_SIG_PARITY: begin
        Out_Valid = 1'b1;
        Out_Coded = 1'b1;
        src_bit   = (^rate_q) ^ (^len_q);
      end
      ST_SIG_RSVD, ST_SIG_TAIL: begin
        Out_Valid = 1'b1;
        Out_Coded = 1'b1;
      end
      ST_PSDU: begin
        Out_Valid = In_Valid;
        In_Ready  = Out_Ready;
        Out_Coded = 1'b1;
        scr_tag   = 1'b1;
        src_bit   = In_Data;
      end
      ST_SERVICE, ST_DTAIL, ST_PAD: begin
        Out_Valid = 1'b1;
        Out_Coded = 1'b1;
        scr_tag   = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer          = Out_Valid & Out_Ready;
  assign Out_Scrambled = scr_tag;
  assign Busy          = busy_q;
  assign Done          = done_q;
  assign Err           = err_q;

`ifdef PLCP_FRAMER_SCRAMBLER_EN
  logic scr_key;
  logic scr_load;
  logic scr_step;

  // Reseed as the last SIGNAL tail bit leaves, so SERVICE starts fresh
  assign scr_load = (state == ST_SIG_TAIL) && xfer && (cnt == TAIL_LAST);
  assign scr_step = scr_tag && xfer;

  plcp_lfsr7 #(
    .SEED (SCR_SEED)
  ) u_lfsr (
    .clk   (Clock),
    .rst_n (Reset),
    .load  (scr_load),
    .step  (scr_step),
    .out   (scr_key)
  );

  // Tail bits are zeroed after scrambling so the decoder trellis terminates
  assign Out_Bit = (state == ST_DTAIL) ? 1'b0 : (src_bit ^ (scr_tag & scr_key));
`else
  logic unused_seed;
  assign unused_seed = ^SCR_SEED;
  assign Out_Bit     = src_bit;
`endif

  // Frame sequencer: advances one bit per output transfer
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sym_cnt <= '0;
      rate_q  <= '0;
      len_q   <= '0;
      ndbps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state == ST_IDLE) begin
        if (Start) begin
          if ((start_ndbps == 8'd0) || (Length == '0)) begin
            err_q <= 1'b1;
          end else begin
            rate_q  <= Rate;
            len_q   <= Length;
            ndbps_q <= start_ndbps;
            cnt     <= '0;
            sym_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= ST_PREAMBLE;
          end
        end
      end else if (xfer) begin
        cnt <= cnt + CNT_W'(1);
        if (scr_tag) begin
          sym_cnt <= sym_next;
        end
        case (state)
          ST_PREAMBLE:
            if (cnt == PRE_LAST) begin
              state <= ST_SIG_RATE;
              cnt   <= '0;
            end
          ST_SIG_RATE:
            if (cnt == RATE_LAST) begin
              state <= ST_SIG_RSVD;
              cnt   <= '0;
            end
          ST_SIG_RSVD: begin
            state <= ST_SIG_LEN;
            cnt   <= '0;
          end
          ST_SIG_LEN:
            if (cnt == LEN_LAST) begin
              state <= ST_SIG_PARITY;
              cnt   <= '0;
            end
          ST_SIG_PARITY: begin
            state <= ST_SIG_TAIL;
            cnt   <= '0;
          end
          ST_SIG_TAIL:
            if (cnt == TAIL_LAST) begin
              state <= ST_SERVICE;
              cnt   <= '0;
            end
          ST_SERVICE:
            if (cnt == SVC_LAST) begin
              state <= ST_PSDU;
              cnt   <= '0;
            end
          ST_PSDU:
            if (cnt == psdu_last) begin
              state <= ST_DTAIL;
              cnt   <= '0;
            end
          ST_DTAIL:
            if (cnt == TAIL_LAST) begin
              cnt <= '0;
              if (sym_next == 8'd0) begin
                state   <= ST_IDLE;
                sym_cnt <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state <= ST_PAD;
              end
            end
          ST_PAD:
            if (sym_next == 8'd0) begin
              state   <= ST_IDLE;
              cnt     <= '0;
              sym_cnt <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_plcp_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_plcp_framer
// Description : Randomised scoreboard bench for plcp_framer. A frame-level
//               reference model pushes the expected bit stream; an
//               independent monitor pops and compares on every transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plcp_framer;

  localparam int LEN_W  = 12;
  localparam int PRE    = 96;
  localparam int BUDGET = 20000;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0;
  logic [3:0]       Rate = 4'd0;
  logic [LEN_W-1:0] Length = '0;
  logic             In_Data = 1'b0;
  logic             In_Valid = 1'b0;
  logic             In_Ready;
  logic             Out_Bit;
  logic             Out_Valid;
  logic             Out_Ready = 1'b0;
  logic             Out_Coded;
  logic             Out_Scrambled;
  logic             Busy;
  logic             Done;
  logic             Err;

  plcp_framer #(
    .PREAMBLE_BITS (PRE),
    .LEN_W         (LEN_W),
    .SCR_SEED      (7'h7F)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Start         (Start),
    .Rate          (Rate),
    .Length        (Length),
    .In_Data       (In_Data),
    .In_Valid      (In_Valid),
    .In_Ready      (In_Ready),
    .Out_Bit       (Out_Bit),
    .Out_Valid     (Out_Valid),
    .Out_Ready     (Out_Ready),
    .Out_Coded     (Out_Coded),
    .Out_Scrambled (Out_Scrambled),
    .Busy          (Busy),
    .Done          (Done),
    .Err           (Err)
  );

  always #5 Clock = ~Clock;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];        // {bit, coded, scrambled}
  bit         psdu_q[$];
  int         psdu_idx = 0;
  int         xfer_cnt = 0;
  int         data_cnt = 0;
  logic [7:0] data_head = 8'd0;
  bit         stall_en = 1'b0;
  int         exp_total = 0;
  // {Out_Bit, Out_Valid, In_Ready, Out_Coded, Out_Scrambled, Busy, Done, Err}
  logic [7:0] s_outs = 8'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ndbps_ref(input logic [3:0] r);
    case (r)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  // Frame-level reference: lay out every field from the frame rules
  task automatic build_frame(input logic [3:0] rate, input int len, output int total);
    logic [LEN_W-1:0] lv;
    bit   d[$];
    int   nd, dbits, nsym, pad, tail_lo;
    logic [6:0] s;
    logic ks, ob;
    lv = LEN_W'(len);
    for (int i = 0; i < PRE; i++) exp_q.push_back({(i % 2 == 0) ? 1'b1 : 1'b0, 2'b00});
    for (int i = 3; i >= 0; i--) exp_q.push_back({rate[i], 2'b10});
    exp_q.push_back(3'b010);
    for (int i = 0; i < LEN_W; i++) exp_q.push_back({lv[i], 2'b10});
    exp_q.push_back({(($countones(rate) + $countones(lv)) % 2 == 1) ? 1'b1 : 1'b0, 2'b10});
    for (int i = 0; i < 6; i++) exp_q.push_back(3'b010);
    nd    = ndbps_ref(rate);
    dbits = 22 + 8 * len;
    nsym  = (dbits + nd - 1) / nd;
    pad   = nsym * nd - dbits;
    for (int i = 0; i < 16; i++) d.push_back(1'b0);
    for (int i = 0; i < 8 * len; i++) d.push_back(psdu_q[i]);
    for (int i = 0; i < 6 + pad; i++) d.push_back(1'b0);
    tail_lo = 16 + 8 * len;
    s = 7'h7F;
    for (int k = 0; k < d.size(); k++) begin
      ob = d[k];
`ifdef PLCP_FRAMER_SCRAMBLER_EN
      ks = s[6] ^ s[3];
      s  = {s[5:0], ks};
      ob = d[k] ^ ks;
      if (k >= tail_lo && k < tail_lo + 6) ob = 1'b0;
`else
      ks = 1'b0;
      s  = s;
`endif
      exp_q.push_back({ob, 2'b11});
    end
    total = PRE + 12 + LEN_W + d.size();
  endtask

  // Scoreboard monitor: pops one expected bit per transfer
  always @(negedge Clock) begin
    logic [2:0] e;
    if (Reset && Out_Valid && Out_Ready) begin
      xfer_cnt++;
      if (Out_Scrambled) begin
        if (data_cnt < 8) data_head[7 - data_cnt] = Out_Bit;
        data_cnt++;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bit: got %b%b%b, expected no transfer", Out_Bit, Out_Coded, Out_Scrambled);
      end else begin
        e = exp_q.pop_front();
        if ({Out_Bit, Out_Coded, Out_Scrambled} !== e) begin
          errors++;
          $display("FAIL stream_bit #%0d: got %b%b%b, expected %b", xfer_cnt, Out_Bit, Out_Coded, Out_Scrambled, e);
        end
      end
    end
    if (Reset && !Busy) begin
      checks++;
      if (Out_Valid || In_Ready || Out_Bit || Out_Coded || Out_Scrambled) begin
        errors++;
        $display("FAIL idle_outputs: got %b%b%b%b%b, expected 00000", Out_Valid, In_Ready, Out_Bit, Out_Coded, Out_Scrambled);
      end
    end
  end

  // One clock of stimulus: sample at negedge, update inputs just after posedge
  task automatic tick();
    bit take;
    @(negedge Clock);
    take   = In_Valid && In_Ready;
    s_outs = {Out_Bit, Out_Valid, In_Ready, Out_Coded, Out_Scrambled, Busy, Done, Err};
    @(posedge Clock);
    #1;
    if (take) psdu_idx++;
    Out_Ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    In_Valid  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    In_Data   = (psdu_idx < psdu_q.size()) ? psdu_q[psdu_idx] : 1'($urandom_range(0, 1));
  endtask

  task automatic start_frame(input logic [3:0] rate, input int len, input bit stall, input bit zero);
    check("queue_empty_before", exp_q.size(), 0);
    exp_q.delete();
    psdu_q.delete();
    for (int i = 0; i < 8 * len; i++) psdu_q.push_back(zero ? 1'b0 : 1'($urandom_range(0, 1)));
    psdu_idx  = 0;
    stall_en  = stall;
    build_frame(rate, len, exp_total);
    xfer_cnt  = 0;
    data_cnt  = 0;
    data_head = 8'd0;
    Start     = 1'b1;
    Rate      = rate;
    Length    = LEN_W'(len);
    In_Valid  = 1'b1;
    In_Data   = psdu_q[0];
    Out_Ready = 1'b1;
    tick();
    Start  = 1'b0;
    Rate   = 4'($urandom);
    Length = LEN_W'($urandom);
    tick();
    check("first_valid", int'(s_outs[6]), 1);
    check("busy_after_start", int'(s_outs[2]), 1);
  endtask

  task automatic finish_frame(input int poke);
    int cyc;
    cyc = 0;
    while (!s_outs[1] && cyc < BUDGET) begin
      if (cyc == poke) begin
        Start  = 1'b1;
        Rate   = 4'b1001;
        Length = LEN_W'(3);
      end else begin
        Start = 1'b0;
      end
      tick();
      cyc++;
    end
    Start = 1'b0;
    check("done_seen", int'(s_outs[1]), 1);
    check("busy_at_done", int'(s_outs[2]), 0);
    check("scoreboard_empty", exp_q.size(), 0);
    check("psdu_consumed", psdu_idx, psdu_q.size());
    check("transfer_count", xfer_cnt, exp_total);
    exp_q.delete();
  endtask

  task automatic err_case(input logic [3:0] rate, input int len);
    Start  = 1'b1;
    Rate   = rate;
    Length = LEN_W'(len);
    tick();
    Start = 1'b0;
    tick();
    check("err_pulse", int'(s_outs[0]), 1);
    check("err_busy", int'(s_outs[2]), 0);
    check("err_valid", int'(s_outs[6]), 0);
    tick();
    check("err_one_cycle", int'(s_outs[0]), 0);
    check("err_stays_idle", int'(s_outs[2]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected termination");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rates [8];
    int         cyc;
    rates = '{4'b1101, 4'b1111, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b0001, 4'b0011};

    Reset = 1'b0;
    repeat (3) tick();
    check("reset_outputs", int'(s_outs), 0);
    Reset = 1'b1;
    tick();
    check("idle_outputs_after_reset", int'(s_outs), 0);

    // 6 Mb/s, 16 bytes, zero PSDU: 288 transfers, 168 data-field bits
    start_frame(4'b1101, 16, 1'b0, 1'b1);
    finish_frame(-1);
    check("frame_288_total", xfer_cnt, 288);
    check("frame_288_data", data_cnt, 168);
`ifdef PLCP_FRAMER_SCRAMBLER_EN
    check("service_head", int'(data_head), 8'b00001110);
`else
    check("service_head", int'(data_head), 0);
`endif

    start_frame(4'b0011, 100, 1'b0, 1'b0);
    finish_frame(-1);
    check("frame_54m_data", data_cnt, 864);

    start_frame(4'b1101, 1, 1'b0, 1'b0);
    finish_frame(-1);
    check("frame_len1_data", data_cnt, 48);

    err_case(4'b0000, 5);
    err_case(4'b1101, 0);
    err_case(4'b1010, 3);

    // Randomised frames with stalls on both sides and a Start while busy
    for (int n = 0; n < 8; n++) begin
      start_frame(rates[$urandom_range(0, 7)], $urandom_range(1, 40), 1'b1, 1'b0);
      finish_frame(30 + n);
    end

    // Reset in the middle of the PSDU, then a complete frame
    start_frame(4'b0101, 20, 1'b1, 1'b0);
    cyc = 0;
    while (psdu_idx < 10 && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    check("reached_psdu", (psdu_idx >= 10) ? 1 : 0, 1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    exp_q.delete();
    tick();
    check("outputs_after_midframe_reset", int'(s_outs), 0);
    start_frame(4'b1011, 12, 1'b1, 1'b0);
    finish_frame(-1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/plcp_framer.md
PLCP_FRAMER -- requirements
Module: plcp_framer

Interface
REQ-001 SHALL have parameter PREAMBLE_BITS, default 96, which sets the preamble length in bits (even, >=2).
REQ-002 SHALL have parameter LEN_W, default 12, which sets the Length width in bits (PSDU bytes).
REQ-003 SHALL have parameter SCR_SEED, default 7'h7F, which sets the scrambler initial state (used only with PLCP_FRAMER_SCRAMBLER_EN).
REQ-004 SHALL have port Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port Start, input, 1 bit: frame request pulse.
REQ-007 SHALL have port Rate, input, 4 bits: SIGNAL RATE code (R1..R4 = Rate[3:0]).
REQ-008 SHALL have port Length, input, LEN_W bits: PSDU length in bytes.
REQ-009 SHALL have ports In_Data (input, 1 bit: PSDU bit), In_Valid (input, 1 bit) and In_Ready (output, 1 bit).
REQ-010 SHALL have ports Out_Bit (output, 1 bit), Out_Valid (output, 1 bit) and Out_Ready (input, 1 bit).
REQ-011 SHALL have ports Out_Coded and Out_Scrambled (outputs, 1 bit each): segment tags qualifying Out_Bit.
REQ-012 SHALL have ports Busy (output, 1 bit), Done (output, 1 bit: one-cycle pulse) and Err (output, 1 bit: one-cycle pulse).

Function
REQ-013 SHALL accept Start only in IDLE and capture Rate and Length on that edge; Start while Busy SHALL be ignored.
REQ-014 SHALL decode N_DBPS from the captured Rate: 1101->24, 1111->36, 0101->48, 0111->72, 1001->96, 1011->144, 0001->192, 0011->216.
REQ-015 SHALL, for any other Rate code or for Length==0, pulse Err for one cycle and stay in IDLE.
REQ-016 SHALL sequence states IDLE, PREAMBLE, SIG_RATE(4 bits), SIG_RSVD(1), SIG_LEN(LEN_W, LSB first), SIG_PARITY(1), SIG_TAIL(6), SERVICE(16), PSDU(8*Length), DTAIL(6), PAD, then IDLE.
REQ-017 SHALL present the first preamble bit with Out_Valid=1 on the cycle after Start is accepted.
REQ-018 SHALL advance a bit only on an output transfer (Out_Valid && Out_Ready); Out_Bit and the tags SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-019 SHALL emit preamble bits as alternating 1,0 starting with 1.
REQ-020 SHALL emit the reserved bit and SIGNAL tail bits as 0, and the parity bit as even parity over RATE, reserved and LENGTH.
REQ-021 SHALL, in PSDU, drive Out_Valid=In_Valid and In_Ready=Out_Ready (combinational pass-through); In_Ready SHALL be 0 in every other state.
REQ-022 SHALL drive Out_Coded=0 in PREAMBLE and 1 from SIG_RATE through PAD.
REQ-023 SHALL drive Out_Scrambled=1 from SERVICE through PAD, else 0.
REQ-024 SHALL emit SERVICE, DTAIL and PAD source bits as 0.
REQ-025 SHALL emit pad = N_SYM*N_DBPS-(22+8*Length) bits, where N_SYM=ceil((22+8*Length)/N_DBPS), tracked by a modulo-N_DBPS counter; pad may be 0.
REQ-026 SHALL pulse Done on the cycle after the last PAD or DTAIL bit transfers, then return to IDLE.
REQ-027 SHALL hold Busy=1 from Start acceptance until Done.
REQ-028 SHALL use a PSDU bit counter of LEN_W+3 bits, with no wrap for Length at its maximum value.

Reset
REQ-029 SHALL, on Reset low at a rising Clock edge, enter IDLE from any state, including mid-frame, and clear all counters.
REQ-030 SHALL hold all outputs at 0 in reset and IDLE (Out_Bit, Out_Valid, In_Ready, tags, Busy, Done, Err).

Configuration
REQ-031 SHALL, with PLCP_FRAMER_SCRAMBLER_EN defined, XOR data-field bits with an internal x^7+x^4+1 scrambler seeded with SCR_SEED at SERVICE entry, stepping once per transfer.
REQ-032 SHALL, with PLCP_FRAMER_SCRAMBLER_EN defined, force the 6 DTAIL output bits to 0 after scrambling.
REQ-033 SHALL, without PLCP_FRAMER_SCRAMBLER_EN, emit data-field bits unscrambled, with Out_Scrambled marking them for the downstream scrambler.

Structure
REQ-034 SHALL take the state enum, RATE codes, the N_DBPS table function, the 16/6 bit constants and the preamble pattern from the shared package plcp_pkg.
REQ-035 SHALL instantiate sub-module plcp_lfsr7 (load, step, out) only under PLCP_FRAMER_SCRAMBLER_EN.

Verification
REQ-036 Rate=1101, Length=16, Out_Ready=1 -> 96 preamble bits + 24 SIGNAL bits (parity=0) + 168 data bits, pad=18, Done at 288 transfers.
REQ-037 Rate=0011, Length=100 -> 864 data bits, pad=42; Rate=1101, Length=1 -> 48 data bits, pad=18.
REQ-038 Rate=0000 or Length=0 -> one Err pulse, Busy stays 0, no Out_Valid.
REQ-039 Random Out_Ready and In_Valid stalls -> output bit stream identical to the unstalled run; no PSDU bit lost or duplicated.
REQ-040 SCRAMBLER_EN, SCR_SEED=7'h7F, all-zero PSDU -> first 8 SERVICE bits 00001110; DTAIL bits all 0.
REQ-041 Reset low during PSDU -> IDLE next edge, all outputs 0; a following Start produces a complete frame.
